// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side controllers.
// Imported by the arbiter, its interface and sub-modules.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  localparam int FRAME_BITS    = 10;
  localparam int TIMEOUT_SLACK = 16;

  function automatic int calc_timeout(
    input int clks_per_bit
  );
    return clks_per_bit * FRAME_BITS
         + TIMEOUT_SLACK;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte producers, the arbiter and the shared uart_tx.
// master is the arbiter side, slave is the producer/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   i_Req;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Grant;
  logic [IDX_W-1:0]     o_Grant_Idx;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;
  logic                 o_Busy;
  logic                 o_Timeout;

  modport master (
    input  i_Req,
    input  i_Req_Byte,
    output o_Grant,
    output o_Grant_Idx,
    output o_Tx_DV,
    output o_Tx_Byte,
    input  i_Tx_Active,
    input  i_Tx_Done,
    output o_Busy,
    output o_Timeout
  );

  modport slave (
    output i_Req,
    output i_Req_Byte,
    input  o_Grant,
    input  o_Grant_Idx,
    input  o_Tx_DV,
    input  o_Tx_Byte,
    output i_Tx_Active,
    output i_Tx_Done,
    input  o_Busy,
    input  o_Timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... with wrap.
// Reusable for any shared-resource controller.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic         found;
  logic [W-1:0] k;

  always_comb begin
    any   = |req;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = W'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin launcher sharing one uart_tx between NUM_REQ producers,
// with a watchdog that recovers if the done pulse never arrives.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 87
) (
  input logic               i_Clock,
  input logic               i_Rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMEOUT = calc_timeout(CLKS_PER_BIT);
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  arb_state_t         state, state_nx;
  logic [IDX_W-1:0]   ptr, ptr_nx;
  logic [WD_W-1:0]    wd, wd_nx;
  logic [NUM_REQ-1:0] grant, grant_nx;
  logic [IDX_W-1:0]   gidx, gidx_nx;
  logic               dv, dv_nx;
  logic [7:0]         tx_byte, tx_byte_nx;
  logic               tmo, tmo_nx;

  logic               rr_any;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_idx;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req (bus.i_Req),
    .ptr (ptr),
    .any (rr_any),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    wd_nx      = wd;
    grant_nx   = '0;
    gidx_nx    = gidx;
    dv_nx      = 1'b0;
    tx_byte_nx = tx_byte;
    tmo_nx     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (rr_any && !bus.i_Tx_Active) begin
          state_nx   = ISSUE;
          ptr_nx     = rr_idx;
          gidx_nx    = rr_idx;
          grant_nx   = rr_gnt;
          dv_nx      = 1'b1;
          tx_byte_nx = bus.i_Req_Byte[{rr_idx, 3'b000} +: 8];
        end
      end
      (state == ISSUE): begin
        // ISSUE itself is the first watchdog cycle
        state_nx = WAIT;
        wd_nx    = WD_W'(1);
      end
      (state == WAIT): begin
        if (wd != WD_W'(TIMEOUT))
          wd_nx = wd + 1'b1;
        if (bus.i_Tx_Done) begin
          state_nx = IDLE;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          state_nx = IDLE;
          tmo_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state   <= IDLE;
      ptr     <= IDX_W'(NUM_REQ - 1);
      wd      <= '0;
      grant   <= '0;
      gidx    <= '0;
      dv      <= 1'b0;
      tx_byte <= 8'h00;
      tmo     <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      wd      <= wd_nx;
      grant   <= grant_nx;
      gidx    <= gidx_nx;
      dv      <= dv_nx;
      tx_byte <= tx_byte_nx;
      tmo     <= tmo_nx;
    end
  end

  assign bus.o_Grant     = grant;
  assign bus.o_Grant_Idx = gidx;
  assign bus.o_Tx_DV     = dv;
  assign bus.o_Tx_Byte   = tx_byte;
  assign bus.o_Busy      = (state != IDLE);
  assign bus.o_Timeout   = tmo;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4, CLKS_PER_BIT=4.
// Outputs sampled on the falling edge; inputs changed there too.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int CPB     = 4;
  localparam int TIMEOUT = 56;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  logic model_en = 1'b0;
  logic m_active = 1'b0;
  logic m_done   = 1'b0;
  logic d_active = 1'b0;
  logic d_done   = 1'b0;

  assign bus.i_Tx_Active = model_en ? m_active : d_active;
  assign bus.i_Tx_Done   = model_en ? m_done : d_done;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m_cnt     = 0;
  int last_done = -100;

  // uart_tx stand-in: busy for 10 bit times, done and idle together
  always @(negedge clk) begin
    m_done = 1'b0;
    if (model_en) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_active  = 1'b0;
          m_done    = 1'b1;
          last_done = cyc;
        end
      end else if (bus.o_Tx_DV) begin
        m_active = 1'b1;
        m_cnt    = CPB * 10;
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_dv(
    input  int limit,
    output int c,
    output bit ok
  );
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (bus.o_Tx_DV === 1'b1) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
  endtask

  int c, t, t2, tc;
  bit ok;

  initial begin
    bus.i_Req      = '0;
    bus.i_Req_Byte = 32'h44A5_2211;
    repeat (3) @(negedge clk);
    chk("rst_hold_outs",
        {bus.o_Grant, bus.o_Grant_Idx, bus.o_Tx_DV,
         bus.o_Tx_Byte, bus.o_Busy, bus.o_Timeout}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_idle_outs",
          {bus.o_Grant, bus.o_Grant_Idx, bus.o_Tx_DV,
           bus.o_Tx_Byte, bus.o_Busy, bus.o_Timeout}, 0);
    end

    // single request from producer 2
    bus.i_Req = 4'b0100;
    @(negedge clk);
    chk("single_grant", bus.o_Grant, 4'b0100);
    chk("single_idx", bus.o_Grant_Idx, 2);
    chk("single_dv", bus.o_Tx_DV, 1);
    chk("single_byte", bus.o_Tx_Byte, 8'hA5);
    chk("single_busy", bus.o_Busy, 1);
    @(negedge clk);
    chk("single_grant_pulse", bus.o_Grant, 0);
    chk("single_dv_pulse", bus.o_Tx_DV, 0);
    chk("single_idx_hold", bus.o_Grant_Idx, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("single_no_redv", bus.o_Tx_DV, 0);
    end
    d_done = 1'b1;
    @(negedge clk);
    d_done    = 1'b0;
    bus.i_Req = '0;
    chk("single_idle", bus.o_Busy, 0);
    @(negedge clk);
    chk("single_no_relaunch", bus.o_Tx_DV, 0);

    // fresh pointer, then all four requesting
    rst_n = 1'b0;
    @(negedge clk);
    rst_n          = 1'b1;
    bus.i_Req_Byte = 32'h1312_1110;
    model_en       = 1'b1;
    bus.i_Req      = 4'hF;
    for (int k = 0; k < 6; k++) begin
      wait_dv(200, c, ok);
      chk("rr_dv_seen", ok, 1);
      if (ok) begin
        chk("rr_idx", bus.o_Grant_Idx, k % 4);
        chk("rr_grant", bus.o_Grant, 1 << (k % 4));
        chk("rr_byte", bus.o_Tx_Byte, 8'h10 + k % 4);
        chk("rr_spacing", (c - last_done) >= 2, 1);
      end
    end
    bus.i_Req = '0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.o_Busy === 1'b0) ok = 1'b1;
    end
    chk("rr_drain", ok, 1);
    model_en = 1'b0;

    // watchdog expiry with done stuck low
    bus.i_Req = 4'b0001;
    wait_dv(5, t, ok);
    chk("to_dv_seen", ok, 1);
    chk("to_idx", bus.o_Grant_Idx, 0);
    bus.i_Req = '0;
    ok = 1'b0;
    tc = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.o_Timeout === 1'b1) begin
        ok = 1'b1;
        tc = cyc;
      end
    end
    chk("to_seen", ok, 1);
    chk("to_delay", tc - t, TIMEOUT);
    chk("to_idle", bus.o_Busy, 0);
    bus.i_Req = 4'b0010;
    @(negedge clk);
    chk("to_pulse_width", bus.o_Timeout, 0);
    chk("to_next_grant", bus.o_Grant, 4'b0010);
    chk("to_next_dv", bus.o_Tx_DV, 1);
    bus.i_Req = '0;

    // done lands on the expiry cycle
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("tie_still_busy", bus.o_Busy, 1);
    d_done = 1'b1;
    @(negedge clk);
    d_done = 1'b0;
    chk("tie_timeout", bus.o_Timeout, 0);
    chk("tie_idle", bus.o_Busy, 0);

    // reset while the old frame is still shifting
    bus.i_Req = 4'b0001;
    @(negedge clk);
    chk("mid_dv", bus.o_Tx_DV, 1);
    d_active = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mid_hold_dv", bus.o_Tx_DV, 0);
      chk("mid_hold_busy", bus.o_Busy, 0);
    end
    d_active = 1'b0;
    @(negedge clk);
    chk("mid_grant", bus.o_Grant, 4'b0001);
    chk("mid_grant_dv", bus.o_Tx_DV, 1);
    bus.i_Req = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. It arbitrates pending requests, launches one byte at a time into the transmitter's `i_Tx_DV`/`i_Tx_Byte` inputs, and holds off further launches until that frame's `o_Tx_Done`. It sits between the producers (loopback path, status reporter, debug console, …) and the `uart_tx` instance inside the `uart` top level. A watchdog recovers the controller if a done pulse never arrives.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 87: must equal the `uart_tx` setting; sizes the watchdog.
- `IDX_W`, `$clog2(NUM_REQ)`: localparam, width of the requester index.
- `i_Clock`  in  1  sole clock.
- `i_Rst_n`  in  1  reset: synchronous, active-low.
- `i_Req`  in  NUM_REQ  level request; bit k high means requester k has a byte ready.
- `i_Req_Byte`  in  8*NUM_REQ  requester k's byte on [8k+7:8k]; must be stable while its `i_Req` bit is high.
- `o_Grant`  out  NUM_REQ  one-hot, one-cycle pulse: the winner's byte has been captured.
- `o_Grant_Idx`  out  IDX_W  index of the most recent winner; holds until the next grant.
- `o_Tx_DV`  out  1  to `uart_tx i_Tx_DV`; one-cycle pulse.
- `o_Tx_Byte`  out  8  to `uart_tx i_Tx_Byte`; registered.
- `i_Tx_Active`  in  1  from `uart_tx o_Tx_Active`.
- `i_Tx_Done`  in  1  from `uart_tx o_Tx_Done`.
- `o_Busy`  out  1  high in any state except IDLE.
- `o_Timeout`  out  1  one-cycle pulse when the watchdog expires.

## Operation
- FSM states are IDLE, ISSUE and WAIT.
- IDLE
  - Launch condition: `i_Req != 0` and `i_Tx_Active == 0`.
  - When the condition holds, choose the winner by round-robin and go to ISSUE.
  - On that same edge, register `o_Tx_Byte` from the winner's byte, `o_Grant_Idx`, and the one-hot `o_Grant`.
- ISSUE (exactly one cycle)
  - Drive `o_Tx_DV=1` and `o_Grant` = the winner's one-hot.
  - Clear the watchdog.
  - Go to WAIT.
  - Ignore `i_Tx_Done` in this cycle; it is stale from the previous frame.
- WAIT
  - Increment the watchdog each cycle.
  - On `i_Tx_Done=1`, go to IDLE.
  - If the watchdog reaches `TIMEOUT = CLKS_PER_BIT*FRAME_BITS + 16` (FRAME_BITS=10) before `i_Tx_Done`, pulse `o_Timeout` and go to IDLE.
  - If done and timeout occur in the same cycle, done wins and `o_Timeout` stays 0.
- Round-robin
  - The pointer holds the last winner.
  - Search order is pointer+1, pointer+2, … with modulo-`NUM_REQ` wrap.
  - The pointer updates only on a grant.
  - After reset the pointer is `NUM_REQ-1`, so requester 0 has first priority.
- Requester handshake
  - On seeing `o_Grant[k]`, requester k either drops `i_Req[k]` or presents its next byte in the following cycle.
  - Requests are sampled only in IDLE, so a single request cannot be taken twice.
- A request dropped after its grant has no effect: the byte is already captured.
- Reset mid-frame
  - The controller returns to IDLE, but `uart_tx` may still be shifting the old frame.
  - The `i_Tx_Active` gate in IDLE blocks any launch until that frame ends.

## Timing
- Reset values: `o_Grant=0`, `o_Grant_Idx=0`, `o_Tx_DV=0`, `o_Tx_Byte=8'h00`, `o_Busy=0`, `o_Timeout=0`, state IDLE, watchdog 0.
- Latency: a request seen in IDLE gives `o_Tx_DV` and `o_Grant` on the next cycle.
- Spacing: the next launch is at least 2 cycles after `i_Tx_Done`, i.e. the WAIT→IDLE edge plus the IDLE→ISSUE edge.
- Outputs: all registered; no combinational path from `i_Req` to any output.
- Watchdog width: `$clog2(TIMEOUT+1)` bits; it saturates and never wraps.

## Structure
- Shared package `uart_pkg`:
  - state enum `arb_state_t` (IDLE, ISSUE, WAIT);
  - `FRAME_BITS=10`;
  - `TIMEOUT_SLACK=16`.
- Sub-module `rr_arbiter`:
  - combinational;
  - inputs: `req[NUM_REQ]` and the pointer;
  - outputs: `any`, one-hot `gnt` and `idx`.
- Reuse `rr_arbiter` for future shared-resource controllers.
- The top FSM, capture registers and watchdog stay in `uart_tx_arbiter`.

## Test plan
- Reset release with `i_Req=0`: all outputs hold their reset values for 20 cycles and `o_Busy=0`.
- Single request: `i_Req=4'b0100`, byte 2 = 8'hA5.
  - `o_Grant=4'b0100`, `o_Grant_Idx=2` and `o_Tx_DV` pulse one cycle later, with `o_Tx_Byte=8'hA5`.
  - No second DV appears before `i_Tx_Done`.
- All four requesting continuously, with a real `uart_tx` model (`CLKS_PER_BIT=4`):
  - grant order is 0,1,2,3,0,…;
  - every DV is at least 2 cycles after the previous `i_Tx_Done`.
- `i_Tx_Done` stuck low after a grant:
  - `o_Timeout` pulses exactly `TIMEOUT` cycles after the ISSUE cycle;
  - the FSM returns to IDLE and the next request is granted.
- Reset asserted during WAIT while `i_Tx_Active=1`, with `i_Req=4'b0001`:
  - no DV is issued while `i_Tx_Active` stays high;
  - the grant comes 1 cycle after `i_Tx_Active` falls.
- `i_Tx_Done` and watchdog expiry in the same cycle: the FSM goes to IDLE with `o_Timeout=0`.
